// File: rtl/id_scan_arb.sv
`default_nettype none
// ============================================================================
// Module   : id_scan_arb
// Brief    : Two-requester arbiter feeding a letter-then-digits identifier
//            recognizer with per-requester saturating match counters.
// Revision : 1.0 - initial release
// ============================================================================
module id_scan_arb #(
    parameter int MAX_LEN = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req0_char,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req1_char,
    input  logic       req1_valid,
    output logic       req1_ready,
    output logic       busy,
    output logic       token_done,
    output logic       token_match,
    output logic       token_ovf,
    output logic       token_src,
    output logic [7:0] match_cnt0,
    output logic [7:0] match_cnt1
);

    typedef enum logic [0:0] {
        ARB = 1'b0,
        OWN = 1'b1
    } ctl_e;

    typedef enum logic [1:0] {
        S0  = 2'd0,
        S1  = 2'd1,
        S2  = 2'd2,
        REJ = 2'd3
    } rec_e;

    localparam logic [7:0] C_MAX_LEN = 8'(MAX_LEN);

    ctl_e       ctl_q, ctl_d;
    rec_e       rec_q, rec_d;
    logic       owner_q, owner_d;
    logic       prio_q, prio_d;
    logic [7:0] len_q, len_d;
    logic       done_q, done_d;
    logic       match_q, match_d;
    logic       ovf_q, ovf_d;
    logic       src_q, src_d;
    logic [7:0] cnt0_q, cnt0_d;
    logic [7:0] cnt1_q, cnt1_d;

    logic [7:0] w_char;
    logic       w_valid;
    logic       w_letter;
    logic       w_digit;

    always_comb begin
        w_char   = owner_q ? req1_char  : req0_char;
        w_valid  = owner_q ? req1_valid : req0_valid;
        w_letter = ((w_char >= 8'h41) && (w_char <= 8'h5A)) ||
                   ((w_char >= 8'h61) && (w_char <= 8'h7A));
        w_digit  = (w_char >= 8'h30) && (w_char <= 8'h39);
    end

    always_comb begin
        ctl_d   = ctl_q;
        rec_d   = rec_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        len_d   = len_q;
        done_d  = 1'b0;
        match_d = match_q;
        ovf_d   = ovf_q;
        src_d   = src_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;

        // Counters follow the registered result, one edge after the pulse starts.
        if (done_q && match_q) begin
            if (!src_q && (cnt0_q != 8'hFF)) cnt0_d = cnt0_q + 8'd1;
            if (src_q && (cnt1_q != 8'hFF))  cnt1_d = cnt1_q + 8'd1;
        end

        case (ctl_q)
            ARB: begin
                if (req0_valid || req1_valid) begin
                    owner_d = (req0_valid && req1_valid) ? prio_q : req1_valid;
                    prio_d  = ~owner_d;
                    ctl_d   = OWN;
                    rec_d   = S0;
                    len_d   = 8'd0;
                end
            end
            OWN: begin
                if (w_valid) begin
                    if (w_letter || w_digit) begin
                        if (len_q == C_MAX_LEN) begin
                            done_d  = 1'b1;
                            match_d = 1'b0;
                            ovf_d   = 1'b1;
                            src_d   = owner_q;
                            ctl_d   = ARB;
                        end else begin
                            len_d = len_q + 8'd1;
                            case (rec_q)
                                S0:      rec_d = w_letter ? S1 : REJ;
                                S1:      rec_d = w_letter ? S1 : S2;
                                S2:      rec_d = w_letter ? S1 : S2;
                                REJ:     rec_d = REJ;
                                default: rec_d = REJ;
                            endcase
                        end
                    end else begin
                        ctl_d = ARB;
                        if (rec_q != S0) begin
                            done_d  = 1'b1;
                            match_d = (rec_q == S2);
                            ovf_d   = 1'b0;
                            src_d   = owner_q;
                        end
                    end
                end
            end
            default: ctl_d = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctl_q   <= ARB;
            rec_q   <= S0;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            len_q   <= 8'd0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
            ovf_q   <= 1'b0;
            src_q   <= 1'b0;
            cnt0_q  <= 8'd0;
            cnt1_q  <= 8'd0;
        end else begin
            ctl_q   <= ctl_d;
            rec_q   <= rec_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            len_q   <= len_d;
            done_q  <= done_d;
            match_q <= match_d;
            ovf_q   <= ovf_d;
            src_q   <= src_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign busy        = (ctl_q == OWN);
    assign req0_ready  = (ctl_q == OWN) && !owner_q;
    assign req1_ready  = (ctl_q == OWN) && owner_q;
    assign token_done  = done_q;
    assign token_match = match_q;
    assign token_ovf   = ovf_q;
    assign token_src   = src_q;
    assign match_cnt0  = cnt0_q;
    assign match_cnt1  = cnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_id_scan_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_scan_arb
// Brief    : Bench for id_scan_arb; instance 0 uses MAX_LEN=16, instance 1 MAX_LEN=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_scan_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [3:0][7:0] chr;
    logic [3:0]      vld;
    logic [3:0]      rdy;
    logic [1:0]      busy, done, match, ovf, src;
    logic [3:0][7:0] cnt;

    id_scan_arb #(.MAX_LEN(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req0_char(chr[0]), .req0_valid(vld[0]), .req0_ready(rdy[0]),
        .req1_char(chr[1]), .req1_valid(vld[1]), .req1_ready(rdy[1]),
        .busy(busy[0]), .token_done(done[0]), .token_match(match[0]),
        .token_ovf(ovf[0]), .token_src(src[0]),
        .match_cnt0(cnt[0]), .match_cnt1(cnt[1])
    );

    id_scan_arb #(.MAX_LEN(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_char(chr[2]), .req0_valid(vld[2]), .req0_ready(rdy[2]),
        .req1_char(chr[3]), .req1_valid(vld[3]), .req1_ready(rdy[3]),
        .busy(busy[1]), .token_done(done[1]), .token_match(match[1]),
        .token_ovf(ovf[1]), .token_src(src[1]),
        .match_cnt0(cnt[2]), .match_cnt1(cnt[3])
    );

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit throttle = 1'b0;

    // Reference model: one token buffer per instance, judged by its first/last char.
    bit           m_own[2], m_owner[2], m_prio[2];
    bit           m_done[2], m_match[2], m_ovf[2], m_src[2];
    int           m_cnt[4];
    byte unsigned m_tok[2][$];
    byte unsigned drv[4][$];
    int           maxlen[2] = '{16, 4};

    function automatic bit is_letter(input byte unsigned c);
        return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
    endfunction

    function automatic bit is_digit(input byte unsigned c);
        return c >= 8'h30 && c <= 8'h39;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic finish_tok(input int i, input bit mt, input bit ov);
        m_done[i]  = 1'b1;
        m_match[i] = mt;
        m_ovf[i]   = ov;
        m_src[i]   = m_owner[i];
        m_own[i]   = 1'b0;
    endtask

    task automatic step();
        for (int i = 0; i < 2; i++) begin
            int k;
            byte unsigned c;
            bit g;
            if (!rst_n) begin
                m_own[i] = 0; m_owner[i] = 0; m_prio[i] = 0;
                m_done[i] = 0; m_match[i] = 0; m_ovf[i] = 0; m_src[i] = 0;
                m_cnt[2*i] = 0; m_cnt[2*i+1] = 0;
                m_tok[i].delete();
            end else begin
                if (m_done[i] && m_match[i]) begin
                    k = 2*i + int'(m_src[i]);
                    if (m_cnt[k] < 255) m_cnt[k]++;
                end
                m_done[i] = 1'b0;
                if (!m_own[i]) begin
                    if (vld[2*i] || vld[2*i+1]) begin
                        g = (vld[2*i] && vld[2*i+1]) ? m_prio[i] : vld[2*i+1];
                        m_owner[i] = g;
                        m_prio[i]  = !g;
                        m_own[i]   = 1'b1;
                        m_tok[i].delete();
                    end
                end else begin
                    k = 2*i + int'(m_owner[i]);
                    if (vld[k]) begin
                        c = chr[k];
                        if (drv[k].size() > 0) void'(drv[k].pop_front());
                        if (is_letter(c) || is_digit(c)) begin
                            if (m_tok[i].size() == maxlen[i]) finish_tok(i, 1'b0, 1'b1);
                            else m_tok[i].push_back(c);
                        end else if (m_tok[i].size() == 0) begin
                            m_own[i] = 1'b0;
                        end else begin
                            finish_tok(i, is_letter(m_tok[i][0]) && is_digit(m_tok[i][$]), 1'b0);
                        end
                    end
                end
            end
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            if (drv[k].size() > 0 && (!throttle || $urandom_range(3) != 0)) begin
                vld[k] = 1'b1;
                chr[k] = drv[k][0];
            end else begin
                vld[k] = 1'b0;
                chr[k] = 8'($urandom);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        step();
        #1;
        drive();
    endtask

    task automatic send(input int k, input string s);
        for (int j = 0; j < s.len(); j++) drv[k].push_back(s[j]);
    endtask

    task automatic push_rand(input int k);
        int n;
        byte unsigned dl[11];
        dl = '{8'h20, 8'h3B, 8'h2C, 8'h00, 8'hFF, 8'h40, 8'h5B, 8'h60, 8'h7B, 8'h2F, 8'h3A};
        n = $urandom_range(0, 20);
        for (int j = 0; j < n; j++) begin
            case ($urandom_range(0, 2))
                0:       drv[k].push_back(8'(8'h61 + $urandom_range(0, 25)));
                1:       drv[k].push_back(8'(8'h41 + $urandom_range(0, 25)));
                default: drv[k].push_back(8'(8'h30 + $urandom_range(0, 9)));
            endcase
        end
        drv[k].push_back(dl[$urandom_range(0, 10)]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input int inst, input int limit, output bit got);
        got = 1'b0;
        for (int n = 0; n < limit && !got; n++) begin
            cycle();
            if (done[inst] === 1'b1) got = 1'b1;
        end
        chk($sformatf("i%0d wait_done", inst), 32'(got), 1);
    endtask

    function automatic bit pending();
        return drv[0].size() > 0 || drv[1].size() > 0 || drv[2].size() > 0 ||
               drv[3].size() > 0 || m_own[0] || m_own[1];
    endfunction

    // Continuous comparison against the model on every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("i%0d busy", i), 32'(busy[i]), 32'(m_own[i]));
                chk($sformatf("i%0d ready0", i), 32'(rdy[2*i]), 32'(m_own[i] && !m_owner[i]));
                chk($sformatf("i%0d ready1", i), 32'(rdy[2*i+1]), 32'(m_own[i] && m_owner[i]));
                chk($sformatf("i%0d done", i), 32'(done[i]), 32'(m_done[i]));
                chk($sformatf("i%0d cnt0", i), 32'(cnt[2*i]), 32'(m_cnt[2*i]));
                chk($sformatf("i%0d cnt1", i), 32'(cnt[2*i+1]), 32'(m_cnt[2*i+1]));
                if (m_done[i]) begin
                    chk($sformatf("i%0d match", i), 32'(match[i]), 32'(m_match[i]));
                    chk($sformatf("i%0d ovf", i), 32'(ovf[i]), 32'(m_ovf[i]));
                    chk($sformatf("i%0d src", i), 32'(src[i]), 32'(m_src[i]));
                end
            end
        end
    end

    initial begin
        bit   got;
        int   nd, ng;
        logic pb;

        rst_n = 1'b0;
        drive();
        cycle();
        chk_en = 1'b1;
        cycle();
        rst_n = 1'b1;
        chk("rst busy", 32'(busy), 0);
        chk("rst ready", 32'(rdy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst match/ovf/src", 32'({match, ovf, src}), 0);
        chk("rst cnt", 32'(cnt), 0);

        // "a1 " on req0: grant, three transfers, then the pulse.
        send(0, "a1 "); send(2, "a1 ");
        drive();
        cycle();
        chk("a1 grant busy", 32'(busy[0]), 1);
        chk("a1 grant ready", 32'(rdy[1:0]), 1);
        cycle(); cycle(); cycle();
        chk("a1 done", 32'(done[0]), 1);
        chk("a1 match", 32'(match[0]), 1);
        chk("a1 src", 32'(src[0]), 0);
        chk("a1 ovf", 32'(ovf[0]), 0);
        cycle(); cycle();
        chk("a1 cnt0", 32'(cnt[0]), 1);
        chk("a1 inst1 cnt0", 32'(cnt[2]), 1);

        // Both valid from reset: req0 first, then req1.
        rst_n = 1'b0;
        send(0, "ab;"); send(1, "x9;"); send(2, "ab;"); send(3, "x9;");
        drive();
        cycle();
        rst_n = 1'b1;
        wait_done(0, 40, got);
        chk("both first src", 32'(src[0]), 0);
        chk("both first match", 32'(match[0]), 0);
        wait_done(0, 40, got);
        chk("both second src", 32'(src[0]), 1);
        chk("both second match", 32'(match[0]), 1);
        cycle(); cycle(); cycle();
        chk("both cnt0", 32'(cnt[0]), 0);
        chk("both cnt1", 32'(cnt[1]), 1);

        // Leading digit rejects; bare delimiters just grant and release.
        do_reset();
        send(0, "9a ");
        drive();
        wait_done(0, 40, got);
        chk("9a match", 32'(match[0]), 0);
        chk("9a ovf", 32'(ovf[0]), 0);
        send(0, "  ");
        drive();
        nd = 0; ng = 0; pb = busy[0];
        for (int n = 0; n < 8; n++) begin
            cycle();
            if (done[0]) nd++;
            if (busy[0] && !pb) ng++;
            pb = busy[0];
        end
        chk("delims pulses", 32'(nd), 0);
        chk("delims grants", 32'(ng), 2);

        // Length limit on the MAX_LEN=4 instance.
        do_reset();
        send(2, "abcde");
        drive();
        wait_done(1, 40, got);
        chk("ovf4 ovf", 32'(ovf[1]), 1);
        chk("ovf4 match", 32'(match[1]), 0);
        chk("ovf4 busy", 32'(busy[1]), 0);
        cycle();
        chk("ovf4 busy next", 32'(busy[1]), 0);

        // Exactly MAX_LEN=16 characters is fine; 17 overflows.
        send(0, "abcdefghijklmno9 ");
        drive();
        wait_done(0, 60, got);
        chk("len16 match", 32'(match[0]), 1);
        chk("len16 ovf", 32'(ovf[0]), 0);
        send(0, "abcdefghijklmnopq ");
        drive();
        wait_done(0, 60, got);
        chk("len17 ovf", 32'(ovf[0]), 1);
        chk("len17 match", 32'(match[0]), 0);

        // Saturation of match_cnt1.
        do_reset();
        throttle = 1'b1;
        for (int n = 0; n < 260; n++) begin
            send(1, "a1 ");
            send(3, "a1 ");
        end
        drive();
        for (int n = 0; n < 6000 && pending(); n++) cycle();
        chk("sat drain", 32'(pending()), 0);
        cycle(); cycle(); cycle();
        chk("sat cnt1", 32'(cnt[1]), 255);
        chk("sat inst1 cnt1", 32'(cnt[3]), 255);
        throttle = 1'b0;

        // Reset mid-token discards it.
        do_reset();
        send(0, "a1");
        drive();
        nd = 0;
        for (int n = 0; n < 4; n++) begin
            cycle();
            if (done[0]) nd++;
        end
        rst_n = 1'b0;
        cycle();
        if (done[0]) nd++;
        rst_n = 1'b1;
        send(1, "b2 ");
        drive();
        cycle();
        chk("rstmid pulses", 32'(nd), 0);
        chk("rstmid grant", 32'(rdy[1:0]), 2);
        wait_done(0, 40, got);
        chk("rstmid src", 32'(src[0]), 1);
        chk("rstmid match", 32'(match[0]), 1);
        cycle(); cycle();
        chk("rstmid cnt1", 32'(cnt[1]), 1);
        chk("rstmid cnt0", 32'(cnt[0]), 0);

        // Random traffic on all four requesters.
        do_reset();
        throttle = 1'b1;
        for (int n = 0; n < 40; n++)
            for (int k = 0; k < 4; k++) push_rand(k);
        drive();
        for (int n = 0; n < 20000 && pending(); n++) cycle();
        chk("rand drain", 32'(pending()), 0);
        cycle(); cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_scan_arb.md
ID_SCAN_ARB -- requirements
Module: id_scan_arb

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 16, the maximum alphanumeric characters per token (range 2..255).
REQ-002 The block SHALL have port clk  input  1  sole clock, all state updates on posedge clk.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have ports req0_char/req1_char  input  8  ASCII character offered by requester 0/1.
REQ-005 The block SHALL have ports req0_valid/req1_valid  input  1  requester 0/1 is offering a character.
REQ-006 The block SHALL have ports req0_ready/req1_ready  output  1  the block accepts the offered character this cycle.
REQ-007 The block SHALL have port busy  output  1  a requester currently owns the recognizer.
REQ-008 The block SHALL have port token_done  output  1  one-cycle pulse, a token has finished.
REQ-009 The block SHALL have port token_match  output  1  the finished token is a valid identifier; meaningful only with token_done.
REQ-010 The block SHALL have port token_ovf  output  1  the finished token was cut at MAX_LEN; meaningful only with token_done.
REQ-011 The block SHALL have port token_src  output  1  owner of the finished token (0/1); meaningful only with token_done.
REQ-012 The block SHALL have ports match_cnt0/match_cnt1  output  8  saturating count of matched tokens per requester.

Function
REQ-013 Character classes SHALL be: LETTER = 0x41-0x5A or 0x61-0x7A; DIGIT = 0x30-0x39; DELIM = all other values.
REQ-014 The controller SHALL have two states: ARB (busy=0, both readys 0) and OWN (busy=1, only the owner's ready=1).
REQ-015 In ARB, if any valid=1, it SHALL grant one requester, record it as owner, and enter OWN on the next edge; no character is consumed in the grant cycle.
REQ-016 With both valids high in ARB, the requester not granted last SHALL win; after reset, requester 0 SHALL have priority.
REQ-017 A transfer SHALL occur only when the owner's valid and ready are both 1; the non-owner's ready SHALL stay 0.
REQ-018 The recognizer SHALL have states S0 (empty), S1 (letters only), S2 (letter then at least one digit), and REJ (leading digit); it SHALL enter S0 on each grant.
REQ-019 Transitions on an accepted LETTER SHALL be: S0->S1, S1->S1, S2->S1, REJ->REJ.
REQ-020 Transitions on an accepted DIGIT SHALL be: S0->REJ, S1->S2, S2->S2, REJ->REJ.
REQ-021 An accepted DELIM in S1/S2/REJ SHALL end the token: on the next cycle token_done=1, token_match=(state==S2), token_ovf=0, token_src=owner; the controller returns to ARB.
REQ-022 An accepted DELIM in S0 SHALL release the grant to ARB without a token_done pulse.
REQ-023 An internal length counter SHALL count accepted LETTER/DIGIT characters in the current token and clear on grant.
REQ-024 An accepted LETTER/DIGIT when length==MAX_LEN SHALL end the token: next cycle token_done=1, token_match=0, token_ovf=1; return to ARB; the character is discarded.
REQ-025 On the token_done cycle with token_match=1, match_cnt[token_src] SHALL increment by 1 and saturate at 255 without wrap.
REQ-026 token_done, token_match, token_ovf, and token_src SHALL be registered; token_done SHALL be high for exactly one cycle per token.
REQ-027 Invalid cycles (owner valid=0) in OWN SHALL hold all state; the grant SHALL never time out.

Reset
REQ-028 While rst_n=0 at posedge clk: state=ARB, recognizer=S0, length=0, priority=requester 0, busy=0, both readys 0, token_done/match/ovf/src=0, match_cnt0=match_cnt1=0.
REQ-029 Reset mid-token SHALL discard the token with no pulse; reset SHALL win over a same-edge counter increment or token end.

Verification
REQ-030 Bench SHALL drive req0 "a1 " (0x61,0x31,0x20), req1 idle -> grant, 3 transfers, token_done=1/match=1/src=0 in the cycle after 0x20; match_cnt0=1.
REQ-031 Bench SHALL hold both valid from reset, req0 "ab;" and req1 "x9;" -> req0 served first (match=0), then req1 (match=1, src=1); match_cnt0=0, match_cnt1=1.
REQ-032 Bench SHALL drive req0 "9a " -> token_done=1, match=0, ovf=0; and "  " (0x20,0x20) -> no pulse, two grant/release cycles.
REQ-033 Bench SHALL drive MAX_LEN=4, req0 "abcde" -> after 'e' accepted: token_done=1, ovf=1, match=0; busy=0 next cycle.
REQ-034 Bench SHALL drive 260 matching tokens "a1 " on req1 -> match_cnt1 stops at 255.
REQ-035 Bench SHALL assert rst_n=0 for one cycle after req0 "a1" (no delimiter), then req1 "b2 " -> no pulse for req0; req1 granted first, match=1, match_cnt1=1, match_cnt0=0.
